// File: rtl/game_pkg.sv
// Shared constants, types and helpers for the monster-defence game director.
// Directions, FSM states and the spawn-direction LFSR definition live here.
package game_pkg;

    localparam int MONSTERS = 12;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1: feedback from bits 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

    // A monster approaching from a side is repelled by striking back toward it.
    function automatic logic [1:0] required_attack(input logic [1:0] dir);
        logic [1:0] req;
        unique case (dir)
            DIR_UP:   req = DIR_DOWN;
            DIR_DOWN: req = DIR_UP;
            DIR_LEFT: req = DIR_RIGHT;
            default:  req = DIR_LEFT;
        endcase
        return req;
    endfunction

endpackage

// File: rtl/game_director_rr_slot_picker.sv
// Round-robin free-slot finder: first set bit of free_i at or after pointer_i,
// wrapping past slot N-1 back to slot 0.
module rr_slot_picker #(
    parameter int N = 12
) (
    input  logic [N-1:0] free_i,
    input  logic [3:0]   pointer_i,
    output logic         found_o,
    output logic [3:0]   index_o
);

    always_comb begin
        found_o = 1'b0;
        index_o = 4'd0;
        for (int k = 0; k < N; k++) begin
            if (!found_o && free_i[(k + int'(pointer_i)) % N]) begin
                found_o = 1'b1;
                index_o = 4'((k + int'(pointer_i)) % N);
            end
        end
    end

endmodule

// File: rtl/game_director.sv
// Game director: paces monster movement, spawns monsters round-robin and
// resolves hero attacks against monsters that have reached the hero.
module game_director #(
    parameter int MONSTERS    = game_pkg::MONSTERS,
    parameter int MOVE_DIV    = 25_000_000,
    parameter int SPAWN_EVERY = 2
) (
    input  logic                  clk_game,
    input  logic                  rst,
    input  logic                  power,
    input  logic                  attack_valid,
    input  logic [1:0]            attack_dir,
    input  logic [MONSTERS-1:0]   arrive,
    input  logic [2*MONSTERS-1:0] slot_dir,
    output logic                  move_tick,
    output logic                  spawn_valid,
    output logic [3:0]            spawn_slot,
    output logic [1:0]            spawn_dir,
    output logic [MONSTERS-1:0]   kill,
    output logic [MONSTERS-1:0]   alive,
    output logic                  running,
    output logic                  game_over,
    output logic [15:0]           score
);
    import game_pkg::*;

    localparam int DIV_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int CNT_W = $clog2(SPAWN_EVERY + 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(MOVE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SPAWN_EVERY);

    state_e               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           ptr_q, ptr_d;
    logic [MONSTERS-1:0]  alive_q, alive_d;
    logic [15:0]          score_q, score_d;
    logic [1:0]           latch_q, latch_d;
    logic                 pend_q, pend_d;

    logic                 tick_raw, tick, miss, do_spawn, found;
    logic [MONSTERS-1:0]  due, hit, kill_vec, spawn_mask;
    logic [CNT_W-1:0]     cnt_inc;
    logic [3:0]           pick_idx, ptr_wrap;
    logic [4:0]           kill_cnt;
    logic [16:0]          score_sum;
    logic [15:0]          score_sat;

    // Search uses pre-tick occupancy so a slot freed by a kill stays empty this tick.
    rr_slot_picker #(.N(MONSTERS)) u_picker (
        .free_i    (~alive_q),
        .pointer_i (ptr_q),
        .found_o   (found),
        .index_o   (pick_idx)
    );

    always_comb begin
        tick_raw = (state_q == ST_RUN) && (div_q == DIV_MAX);
        // A power press in the same cycle wins: the tick resolves nothing.
        tick     = tick_raw && !power;
        due      = alive_q & arrive & {MONSTERS{tick}};
        hit      = '0;
        for (int i = 0; i < MONSTERS; i++) begin
            hit[i] = pend_q && (latch_q == required_attack(slot_dir[2*i +: 2]));
        end
        kill_vec = due & hit;
        miss     = |(due & ~hit);
        cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        do_spawn = tick && !miss && found && (cnt_inc == CNT_MAX);
        spawn_mask = '0;
        for (int i = 0; i < MONSTERS; i++) begin
            spawn_mask[i] = do_spawn && (pick_idx == 4'(i));
        end
        kill_cnt = '0;
        for (int i = 0; i < MONSTERS; i++) begin
            kill_cnt = kill_cnt + {4'd0, kill_vec[i]};
        end
        score_sum = {1'b0, score_q} + {12'd0, kill_cnt};
        score_sat = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        ptr_wrap  = (pick_idx == 4'(MONSTERS - 1)) ? 4'd0 : pick_idx + 4'd1;
    end

    always_comb begin
        state_d = state_q;
        div_d   = '0;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        alive_d = alive_q;
        score_d = score_q;
        latch_d = latch_q;
        pend_d  = pend_q;
        unique case (state_q)
            ST_IDLE: begin
                if (power) begin
                    state_d = ST_RUN;
                    alive_d = '0;
                    score_d = '0;
                    cnt_d   = '0;
                    ptr_d   = '0;
                    latch_d = '0;
                    pend_d  = 1'b0;
                end
            end
            ST_RUN: begin
                lfsr_d = lfsr_next(lfsr_q);
                if (power) begin
                    state_d = ST_IDLE;
                end else if (miss) begin
                    state_d = ST_OVER;
                end else begin
                    div_d = tick_raw ? '0 : div_q + DIV_W'(1);
                    if (tick) begin
                        pend_d  = 1'b0;
                        alive_d = (alive_q & ~kill_vec) | spawn_mask;
                        score_d = score_sat;
                        cnt_d   = do_spawn ? '0 : cnt_inc;
                        if (do_spawn) ptr_d = ptr_wrap;
                    end
                    if (attack_valid) begin
                        latch_d = attack_dir;
                        pend_d  = 1'b1;
                    end
                end
            end
            ST_OVER: begin
                if (power) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_game or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            cnt_q   <= '0;
            ptr_q   <= '0;
            alive_q <= '0;
            score_q <= '0;
            latch_q <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            alive_q <= alive_d;
            score_q <= score_d;
            latch_q <= latch_d;
            pend_q  <= pend_d;
        end
    end

    // move_tick, spawn_valid and kill are single-cycle strobes; nothing back-pressures them.
    assign move_tick   = tick_raw;
    assign spawn_valid = do_spawn;
    assign spawn_slot  = do_spawn ? pick_idx : 4'd0;
    assign spawn_dir   = do_spawn ? lfsr_q[1:0] : 2'b00;
    assign kill        = kill_vec & {MONSTERS{~miss}};
    assign alive       = alive_q;
    assign running     = (state_q == ST_RUN);
    assign game_over   = (state_q == ST_OVER);
    assign score       = score_q;

endmodule
